// File: rtl/rgb_code_sequencer_pkg.sv
// Purpose: shared types and constants for the RGB decoder code sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_e FSM encoding, CODE_W code width, CODE_LAST final code.
package rgb_seq_pkg;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_LAST = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rgb_code_sequencer_if.sv
// Purpose: control, code and colour signals between a controller/decoder and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; control inputs are pulses/levels sampled every cycle.
// Ports: start/stop/step pulses, hold/loop_en levels, dwell; code_o out to the decoder,
//        rgb_i back from it; rgb_o to LEDs; busy/done/wrap status.
//        duty (brightness) exists only when RGB_SEQ_PWM_EN is defined.
interface rgb_seq_if #(
  parameter int DWELL_W = 16
`ifdef RGB_SEQ_PWM_EN
  , parameter int PWM_W = 4
`endif
);
  import rgb_seq_pkg::*;

  logic               start;
  logic               stop;
  logic               hold;
  logic               step;
  logic               loop_en;
  logic [DWELL_W-1:0] dwell;
  logic [CODE_W-1:0]  code_o;
  logic [2:0]         rgb_i;
`ifdef RGB_SEQ_PWM_EN
  logic [PWM_W-1:0]   duty;
`endif
  logic [2:0]         rgb_o;
  logic               busy;
  logic               done;
  logic               wrap;

  // master: the controller plus the external decoder feeding rgb_i
  modport master (
    output start, stop, hold, step, loop_en, dwell, rgb_i,
`ifdef RGB_SEQ_PWM_EN
    output duty,
`endif
    input  code_o, rgb_o, busy, done, wrap
  );

  // slave: the sequencer itself
  modport slave (
    input  start, stop, hold, step, loop_en, dwell, rgb_i,
`ifdef RGB_SEQ_PWM_EN
    input  duty,
`endif
    output code_o, rgb_o, busy, done, wrap
  );

endinterface

// File: rtl/rgb_code_sequencer_pwm_gen.sv
// Purpose: free-running PWM counter and duty compare for LED dimming.
// Latency: pwm_on is combinational from the registered counter.
// Backpressure: none; runs every cycle.
// Ports: clk, rst_n, duty (on-cycles per 2^PWM_W period), pwm_on (high while counter < duty).
module rgb_pwm_gen #(
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_on
);

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // duty=0 never on; duty=max is on for all but one count of the period
  assign pwm_on = (pwm_cnt < duty);

endmodule

// File: rtl/rgb_code_sequencer.sv
// Purpose: steps the 4-bit switch code through 0..15 with a programmable dwell and registers the decoder's RGB.
// Latency: all outputs registered; rgb_o trails code_o by one cycle.
// Backpressure: none; hold freezes the sweep, step advances one code while paused.
// Ports: clk, rst_n (async active-low), bus (rgb_seq_if.slave).
// Option: RGB_SEQ_PWM_EN adds the duty input and PWM dimming of rgb_o via rgb_pwm_gen.
module rgb_code_sequencer #(
  parameter int DWELL_W = 16
`ifdef RGB_SEQ_PWM_EN
  , parameter int PWM_W = 4
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  rgb_seq_if.slave bus
);
  import rgb_seq_pkg::*;

  state_e             state;
  logic [CODE_W-1:0]  code_q;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic               busy_q;
  logic               done_q;
  logic               wrap_q;
  logic [2:0]         rgb_q;
  logic [2:0]         rgb_src;
  logic               to_idle;

`ifdef RGB_SEQ_PWM_EN
  logic pwm_on;

  rgb_pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty   (bus.duty),
    .pwm_on (pwm_on)
  );

  assign rgb_src = bus.rgb_i & {3{pwm_on}};
`else
  assign rgb_src = bus.rgb_i;
`endif

  // Blank the LEDs on the same edge that lands (or stays) in IDLE.
  assign to_idle = bus.stop || ((state == IDLE) && !bus.start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code_q  <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      rgb_q   <= 3'b000;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      rgb_q  <= to_idle ? 3'b000 : rgb_src;

      if (bus.stop) begin
        state  <= IDLE;
        code_q <= '0;
        cnt    <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              state   <= RUN;
              code_q  <= '0;
              cnt     <= '0;
              dwell_q <= bus.dwell;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            // hold wins over a terminal count in the same cycle
            if (bus.hold) begin
              state <= PAUSE;
            end else if (cnt == dwell_q) begin
              cnt <= '0;
              if (code_q == CODE_LAST) begin
                if (bus.loop_en) begin
                  code_q <= '0;
                  wrap_q <= 1'b1;
                end else begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end
              end else begin
                code_q <= code_q + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PAUSE: begin
            // counter keeps its frozen value on resume
            if (!bus.hold) begin
              state <= RUN;
            end else if (bus.step) begin
              code_q <= code_q + 1'b1;
              cnt    <= '0;
              if (code_q == CODE_LAST) wrap_q <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.code_o = code_q;
  assign bus.rgb_o  = rgb_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: doc/rgb_code_sequencer.md
# rgb_code_sequencer

Sequencer that drives the 4-bit switch code {a,b,c,d} into the combinational RGB colour decoder and steps it through all 16 codes with a programmable dwell. It takes the decoder's R,G,B back, registers them and (optionally) PWM-dims them for the LED pins. It provides run/pause/single-step/stop control, so the decoder can be demonstrated or swept on hardware without manual switch toggling.

## Interface
- DWELL_W, 16, width of dwell count
- PWM_W, 4, width of PWM duty/counter (used only with RGB_SEQ_PWM_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin sweep at code 0
- stop  in  1  pulse; abort to IDLE
- hold  in  1  level; freeze sweep while high
- step  in  1  pulse; advance one code while paused
- loop_en  in  1  1 = wrap 15->0 and continue, 0 = stop at 15
- dwell  in  DWELL_W  cycles per code minus one; latched at start
- code_o  out  4  {a,b,c,d} to decoder, a = bit 3
- rgb_i  in  3  {R,G,B} from decoder
- duty  in  PWM_W  brightness (present only with RGB_SEQ_PWM_EN)
- rgb_o  out  3  {R,G,B} to LED pins
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle pulse on entering DONE
- wrap  out  1  one-cycle pulse on any 15->0 advance

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset: IDLE, code_o=0, dwell counter=0, dwell_q=0, busy=0, done=0, wrap=0, rgb_o=0.
- Control priority per cycle: stop > start > hold > step > dwell advance.
- stop in any state: next state IDLE, code_o=0, counter=0.
- IDLE/DONE + start: RUN, code_o=0, counter=0, dwell_q<=dwell. start ignored in RUN/PAUSE.
- RUN: counter increments each cycle; at counter==dwell_q, counter<=0 and code advances. dwell_q=0 means one cycle per code.
- Advance from 15: loop_en=1 -> code 0, wrap pulse, stay RUN; loop_en=0 -> DONE, code_o held 15, done pulse.
- RUN + hold: PAUSE next cycle; counter frozen; hold beats a same-cycle terminal count (no advance).
- PAUSE + step: code+1 (15->0 always wraps, wrap pulse, regardless of loop_en), counter<=0. step ignored outside PAUSE.
- PAUSE + hold low: RUN, counter resumes from frozen value.
- DONE: busy=0, code_o=15, rgb_o keeps showing code 15.
- rgb_o: registered rgb_i; forced 000 in IDLE.
- Mid-run changes to dwell are ignored until next start.

## Timing
- code_o, busy, state change on the edge that samples the control; all outputs registered.
- start sampled at edge N: code_o=0 after N; first advance after edge N+dwell_q+1.
- rgb_o lags code_o by exactly 1 cycle (decoder is combinational).
- done/wrap high for exactly the cycle following the advancing edge.
- Asynchronous reset mid-sweep: all outputs to reset values immediately, no glitch on release.

## Configuration
- RGB_SEQ_PWM_EN defined: free-running PWM_W-bit counter pwm_cnt; rgb_o = registered (rgb_i & {3{pwm_cnt < duty}}), still forced 000 in IDLE; duty=0 -> always off, duty=2^PWM_W-1 -> on (2^PWM_W-1)/2^PWM_W of cycles. duty port present.
- Not defined: no PWM counter, no duty port, rgb_o = registered rgb_i.

## Structure
- Package rgb_seq_pkg: state_e enum (IDLE, RUN, PAUSE, DONE), CODE_W=4, CODE_LAST=4'hF.
- Sub-module rgb_pwm_gen (counter + compare), instantiated only under RGB_SEQ_PWM_EN.
- Decoder instantiated outside this block; bench connects code_o/rgb_i through it.

## Test plan
- Reset, then start, dwell=0, loop_en=0 -> code_o 0,1,...,15 on consecutive cycles, done pulse once, state DONE, busy=0.
- dwell=3, loop_en=1 -> each code held 4 cycles; after 15 code_o=0 with single wrap pulse; sweep continues.
- hold high at counter=2 of code 5, two step pulses, hold low -> code_o 7, counter restarts at 0, 4-cycle dwell.
- stop while in PAUSE at code 9 -> code_o=0, busy=0, rgb_o=000 next cycle; start again restarts at code 0.
- rst_n asserted mid-RUN at code 12 -> code_o=0, rgb_o=000, done/wrap=0 immediately.
- RGB_SEQ_PWM_EN, PWM_W=4, duty=4, rgb_i=111 -> rgb_o=111 for 4 of every 16 cycles; duty=0 -> always 000.
